// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store unit bus master: alignment check, lane steering, timeout
// One access at a time: IDLE -> REQ -> DONE, or IDLE -> DONE on a misaligned address.
module lsu_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        tmo,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, cnt;
  logic        adel_q, ades_q, tmo_q;
  logic        in_store, in_misal, q_store, cnt_last;
  logic [3:0]  be_q;
  logic [31:0] wlane_q, load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign in_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  assign q_store  = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    in_misal = 1'b0;
    case (op)
      OP_LW, OP_SW:         in_misal = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: in_misal = addr[0];
      default:              in_misal = 1'b0;
    endcase
  end

  // Byte enables and replicated store data derived from the latched access.
  always_comb begin
    be_q    = 4'b1111;
    wlane_q = wdata_q;
    case (op_q)
      OP_LH, OP_LHU, OP_SH: begin
        be_q    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_q = {wdata_q[15:0], wdata_q[15:0]};
      end
      OP_LB, OP_LBU, OP_SB: begin
        be_q    = 4'b0001 << addr_q[1:0];
        wlane_q = {4{wdata_q[7:0]}};
      end
      default: begin
        be_q    = 4'b1111;
        wlane_q = wdata_q;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (op_q)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = in_misal ? DONE : REQ;
      REQ:     if (mem_ready || cnt_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt     <= 32'h0;
      rdata   <= 32'h0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            adel_q <= in_misal && !in_store;
            ades_q <= in_misal && in_store;
            tmo_q  <= 1'b0;
            cnt    <= 32'h0;
            if (!in_misal) begin
              op_q    <= op;
              addr_q  <= addr;
              wdata_q <= wdata;
            end
          end
        end
        REQ: begin
          // A handshake on the terminal cycle takes priority over the timeout.
          if (mem_ready) begin
            if (!q_store) rdata <= load_ext;
          end else if (cnt_last) begin
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && q_store;
  assign mem_be    = mem_req ? be_q : 4'b0000;
  assign mem_wdata = mem_req ? wlane_q : 32'h0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign done      = (state == DONE);
  assign adel      = done && adel_q;
  assign ades      = done && ades_q;
  assign tmo       = done && tmo_q;
  assign busy      = (state != IDLE) || start;

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - scoreboard bench for lsu_master with directed accesses
// Stimulus pushes expected completions; a negedge monitor pops them on each done pulse.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, adel, ades, tmo;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lsu_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .adel(adel), .ades(ades), .tmo(tmo),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      rsp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rdata, e.rdata);
        chk("rsp_adel", {31'h0, adel}, {31'h0, e.adel});
        chk("rsp_ades", {31'h0, ades}, {31'h0, e.ades});
        chk("rsp_tmo", {31'h0, tmo}, {31'h0, e.tmo});
      end
    end
  end

  // ready_at: REQ cycle index (0-based) where mem_ready is raised; -1 never.
  task automatic do_access(input logic [2:0] a_op, input logic [31:0] a_addr,
                           input logic [31:0] a_wdata, input int ready_at,
                           input logic [31:0] rword, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic e_we,
                           input int e_cycles, input rsp_t e_rsp);
    int n;
    @(negedge clk);
    start = 1'b1; op = a_op; addr = a_addr; wdata = a_wdata;
    exp_q.push_back(e_rsp);
    #1 chk("busy_on_start", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000; addr = 32'hDEAD_BEEF; wdata = 32'hFFFF_FFFF;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) break;
      chk("req_we", {31'h0, mem_we}, {31'h0, e_we});
      chk("req_addr", mem_addr, {a_addr[31:2], 2'b00});
      chk("req_be", {28'h0, mem_be}, {28'h0, e_be});
      chk("req_wdata", mem_wdata, e_wdata);
      chk("req_busy", {31'h0, busy}, 32'h1);
      mem_ready = (n == ready_at);
      mem_rdata = rword;
      n++;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    chk("req_cycles", n, e_cycles);
    chk("done_latency", {31'h0, done}, 32'h1);
    chk("idle_we", {31'h0, mem_we}, 32'h0);
    chk("idle_be", {28'h0, mem_be}, 32'h0);
    chk("idle_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    chk("done_width", {31'h0, done}, 32'h0);
    chk("back_idle_busy", {31'h0, busy}, 32'h0);
  endtask

  function automatic rsp_t mk(input logic [31:0] r, input logic a, input logic s, input logic t);
    rsp_t x;
    x.rdata = r; x.adel = a; x.ades = s; x.tmo = t;
    return x;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {26'h0, busy, done, adel, ades, tmo, mem_req}, 32'h0);
    chk("rst_mem", {27'h0, mem_we, mem_be} | mem_addr | mem_wdata, 32'h0);
    reset = 1'b1;

    // op, addr, wdata, ready_at, rword, be, wdata_lanes, we, req_cycles, response
    do_access(3'b101, 32'h0000_1004, 32'h1234_5678, 0, 32'h0, 4'b1111, 32'h1234_5678, 1'b1, 1, mk(32'h0, 0, 0, 0));
    do_access(3'b011, 32'h0000_0003, 32'h0, 0, 32'h80FF_0000, 4'b1000, 32'h0, 1'b0, 1, mk(32'hFFFF_FF80, 0, 0, 0));
    do_access(3'b100, 32'h0000_0003, 32'h0, 0, 32'h80FF_0000, 4'b1000, 32'h0, 1'b0, 1, mk(32'h0000_0080, 0, 0, 0));
    do_access(3'b110, 32'h0000_0002, 32'h0000_BEEF, 3, 32'h0, 4'b1100, 32'hBEEF_BEEF, 1'b1, 4, mk(32'h0000_0080, 0, 0, 0));
    do_access(3'b000, 32'h0000_0006, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 0, mk(32'h0000_0080, 1, 0, 0));
    do_access(3'b110, 32'h0000_0001, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1'b0, 0, mk(32'h0000_0080, 0, 1, 0));
    do_access(3'b000, 32'h0000_0010, 32'h0, -1, 32'h5555_5555, 4'b1111, 32'h0, 1'b0, 4, mk(32'h0000_0080, 0, 0, 1));
    do_access(3'b000, 32'h0000_0020, 32'h0, 3, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0, 4, mk(32'hCAFE_F00D, 0, 0, 0));
    do_access(3'b001, 32'h0000_0042, 32'h0, 1, 32'h8001_1234, 4'b1100, 32'h0, 1'b0, 2, mk(32'hFFFF_8001, 0, 0, 0));
    do_access(3'b010, 32'h0000_0040, 32'h0, 0, 32'h8001_9234, 4'b0011, 32'h0, 1'b0, 1, mk(32'h0000_9234, 0, 0, 0));
    do_access(3'b011, 32'h0000_0041, 32'h0, 0, 32'h0000_7F00, 4'b0010, 32'h0, 1'b0, 1, mk(32'h0000_007F, 0, 0, 0));
    do_access(3'b111, 32'h0000_0051, 32'h0000_00A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1, mk(32'h0000_007F, 0, 0, 0));

    // Reset in the middle of a request abandons it silently.
    @(negedge clk);
    start = 1'b1; op = 3'b000; addr = 32'h0000_0080;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort_req_before", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req_after", {31'h0, mem_req}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    reset = 1'b1;
    do_access(3'b000, 32'h0000_0100, 32'h0, 1, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 2, mk(32'h1122_3344, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255: the maximum number of REQ cycles allowed before the access is aborted.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: the pipeline requests an access this cycle.
REQ-005 The module SHALL have port op, input, 3 bits, encoded as: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
REQ-006 The module SHALL have port addr, input, 32 bits: the byte address.
REQ-007 The module SHALL have port wdata, input, 32 bits: the store data, right-aligned.
REQ-008 The module SHALL have port busy, output, 1 bit: stall to the pipeline.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port rdata, output, 32 bits: the extended load result.
REQ-011 The module SHALL have ports adel, ades and tmo, each output, 1 bit: load-misaligned, store-misaligned and timeout flags, valid while done is high.
REQ-012 The module SHALL have port mem_req, output, 1 bit: request valid to memory.
REQ-013 The module SHALL have port mem_we, output, 1 bit: write enable to memory.
REQ-014 The module SHALL have port mem_addr, output, 32 bits: the word address, {addr[31:2],2'b00}.
REQ-015 The module SHALL have port mem_be, output, 4 bits: byte enables, where bit i covers bits 8i+7:8i.
REQ-016 The module SHALL have port mem_wdata, output, 32 bits: the lane-replicated store data.
REQ-017 The module SHALL have port mem_ready, input, 1 bit: memory accepts or completes the access this cycle.
REQ-018 The module SHALL have port mem_rdata, input, 32 bits: the full word read, valid when mem_ready is high.

Function
REQ-019 The FSM SHALL have states IDLE, REQ and DONE.
REQ-020 In IDLE, start=1 with an aligned address SHALL latch op, addr and wdata and move to REQ on the next edge.
REQ-021 Alignment SHALL be defined as: lw/sw need addr[1:0]=00, lh/lhu/sh need addr[0]=0, and byte ops are always aligned.
REQ-022 In IDLE, start=1 with a misaligned address SHALL go to DONE with adel (loads) or ades (stores) set, and mem_req SHALL never assert for that access.
REQ-023 In REQ, mem_req SHALL be 1, and mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable from the latched values until the handshake completes.
REQ-024 The handshake SHALL complete on the first edge in REQ where mem_ready=1; loads then capture the extended data into rdata, and the FSM moves to DONE.
REQ-025 mem_ready SHALL be ignored outside REQ.
REQ-026 mem_be SHALL be: word 1111; half 0011 or 1100 by addr[1]; byte one-hot at addr[1:0].
REQ-027 mem_wdata SHALL be: sw wdata; sh {wdata[15:0],wdata[15:0]}; sb wdata[7:0] replicated four times.
REQ-028 Load extraction SHALL select the lane given by addr[1:0]; lh/lb sign-extend, lhu/lbu zero-extend, and lw passes the word through.
REQ-029 rdata SHALL hold its value until the next completed load; stores and errors SHALL NOT change it.
REQ-030 A cycle counter SHALL clear on entry to REQ and increment each REQ cycle in which mem_ready=0.
REQ-031 When the counter reaches TIMEOUT, the FSM SHALL drop mem_req and go to DONE with tmo=1.
REQ-032 If mem_ready=1 on the same edge the counter reaches TIMEOUT, the handshake SHALL win and tmo SHALL stay 0.
REQ-033 In DONE, done=1 for exactly one cycle, then the FSM SHALL return to IDLE; adel, ades and tmo SHALL be 0 outside DONE.
REQ-034 busy SHALL be 1 whenever state is not IDLE, and also combinationally 1 in IDLE when start=1.
REQ-035 start SHALL be ignored when not in IDLE.
REQ-036 Back-to-back accesses SHALL be spaced at a minimum of 3 cycles (IDLE, REQ, DONE).
REQ-037 When mem_req=0, mem_we, mem_be and mem_wdata SHALL be driven to 0.

Reset
REQ-038 reset=0 at an edge SHALL force IDLE and clear the counter and latched fields.
REQ-039 reset=0 at an edge SHALL set rdata=0 and busy=done=adel=ades=tmo=mem_req=mem_we=0, and mem_addr=mem_be=mem_wdata=0.
REQ-040 Reset asserted while in REQ SHALL drop mem_req on the following cycle with no done pulse; the abandoned access SHALL NOT be reported.

Verification
REQ-041 sw, addr=0x0000_1004, wdata=0x1234_5678, mem_ready=1 on the first REQ cycle -> mem_addr=0x1004, mem_be=1111, mem_wdata=0x12345678, mem_we=1, done 2 cycles after start.
REQ-042 lb, addr=0x0000_0003, mem_rdata=0x80FF_0000 -> mem_be=1000, rdata=0xFFFF_FF80; lbu at the same address -> rdata=0x0000_0080.
REQ-043 sh, addr=0x0000_0002, wdata=0x0000_BEEF, mem_ready delayed 3 cycles -> mem_req high 4 cycles, outputs stable, mem_be=1100, mem_wdata=0xBEEF_BEEF, busy high throughout.
REQ-044 lw, addr=0x0000_0006 -> no mem_req; done with adel=1; rdata unchanged. sh, addr=0x0000_0001 -> ades=1.
REQ-045 TIMEOUT=4, lw with mem_ready held 0 -> mem_req drops after 4 REQ cycles; done with tmo=1. A second run with mem_ready=1 on the terminal cycle -> tmo=0 and the data is captured.
REQ-046 Reset pulled low during REQ -> next cycle mem_req=0, busy=0, no done pulse; a subsequent start proceeds normally.
